// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver that turns arrow and S key makes
// into single-cycle game commands and exposes every valid byte for debug.
// Optional build macro: PS2_PARITY_CHECK_EN (reject frames failing odd parity).
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [3:0] direction,
    output logic       start,
    output logic [7:0] scancode,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic {F_IDLE, F_RECV} frame_state_t;
    typedef enum logic [1:0] {C_BASE, C_EXT, C_BRK, C_EXT_BRK} code_state_t;

    logic            r_clk_meta, r_clk_sync, r_clk_prev;
    logic            r_dat_meta, r_dat_sync;
    logic            w_fall;
    logic            w_dat;

    frame_state_t    r_fstate, w_fstate_next;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [WD_W-1:0] r_wd_cnt;
    logic            w_start_bit, w_shift, w_done, w_timeout, w_frame_ok;

    code_state_t     r_cstate, w_cstate_next;
    logic            w_make, w_break, w_ext;
    logic [4:0]      w_key;
    logic [4:0]      r_held;

    // Two-flop synchronisers plus previous-clock register for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_meta <= 1'b0;
            r_clk_sync <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_meta <= 1'b0;
            r_dat_sync <= 1'b0;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync;
    assign w_dat  = r_dat_sync;

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    // Capture the parity bit (bit index 8) for the odd-parity check
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parity <= 1'b0;
        end else if (w_shift && r_bit_cnt == 4'd8) begin
            r_parity <= w_dat;
        end
    end

    assign w_frame_ok = w_dat & (^{r_parity, r_shift});
`else
    assign w_frame_ok = w_dat;
`endif

    // Frame FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fstate <= F_IDLE;
        end else begin
            r_fstate <= w_fstate_next;
        end
    end

    // Frame FSM next state: start bit, bit shifting, stop bit and watchdog abort
    always_comb begin
        w_fstate_next = r_fstate;
        w_start_bit   = 1'b0;
        w_shift       = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        case (r_fstate)
            F_IDLE: begin
                if (w_fall && !w_dat) begin
                    w_fstate_next = F_RECV;
                    w_start_bit   = 1'b1;
                end
            end
            F_RECV: begin
                if (w_fall) begin
                    if (r_bit_cnt == 4'd9) begin
                        w_fstate_next = F_IDLE;
                        w_done        = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end else if (r_wd_cnt == WD_LIMIT) begin
                    w_fstate_next = F_IDLE;
                    w_timeout     = 1'b1;
                end
            end
            default: w_fstate_next = F_IDLE;
        endcase
    end

    // Frame datapath: shift register, bit counter, watchdog and byte strobes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wd_cnt   <= '0;
            scancode   <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt < 4'd8) begin
                    r_shift <= {w_dat, r_shift[7:1]};
                end
            end else if (w_start_bit || w_done || w_timeout) begin
                r_bit_cnt <= '0;
            end

            if (r_fstate == F_RECV && !w_fall && !w_timeout) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end

            scan_valid <= w_done & w_frame_ok;
            frame_err  <= (w_done & ~w_frame_ok) | w_timeout;
            if (w_done && w_frame_ok) begin
                scancode <= r_shift;
            end
        end
    end

    // Code FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cstate <= C_BASE;
        end else begin
            r_cstate <= w_cstate_next;
        end
    end

    // Code FSM next state: classify each valid byte as prefix, make or break
    always_comb begin
        w_cstate_next = r_cstate;
        w_make        = 1'b0;
        w_break       = 1'b0;
        w_ext         = 1'b0;
        if (scan_valid) begin
            case (r_cstate)
                C_BASE: begin
                    if (scancode == 8'hE0) begin
                        w_cstate_next = C_EXT;
                    end else if (scancode == 8'hF0) begin
                        w_cstate_next = C_BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                C_EXT: begin
                    if (scancode == 8'hF0) begin
                        w_cstate_next = C_EXT_BRK;
                    end else begin
                        w_make        = 1'b1;
                        w_ext         = 1'b1;
                        w_cstate_next = C_BASE;
                    end
                end
                C_BRK: begin
                    w_break       = 1'b1;
                    w_cstate_next = C_BASE;
                end
                C_EXT_BRK: begin
                    w_break       = 1'b1;
                    w_ext         = 1'b1;
                    w_cstate_next = C_BASE;
                end
                default: w_cstate_next = C_BASE;
            endcase
        end
    end

    // Key map: [4] S, [3] up, [2] down, [1] left, [0] right
    always_comb begin
        w_key = '0;
        if (w_ext) begin
            case (scancode)
                8'h75:   w_key[3] = 1'b1;
                8'h72:   w_key[2] = 1'b1;
                8'h6B:   w_key[1] = 1'b1;
                8'h74:   w_key[0] = 1'b1;
                default: w_key = '0;
            endcase
        end else if (scancode == 8'h1B) begin
            w_key[4] = 1'b1;
        end
    end

    // Held flags suppress typematic repeats; pulses fire only on a fresh make
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_held    <= '0;
            direction <= '0;
            start     <= 1'b0;
        end else begin
            direction <= '0;
            start     <= 1'b0;
            if (w_make) begin
                direction <= w_key[3:0] & ~r_held[3:0];
                start     <= w_key[4] & ~r_held[4];
                r_held    <= r_held | w_key;
            end else if (w_break) begin
                r_held <= r_held & ~w_key;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and randomized PS/2 frames checked against a
// key-level reference model (prefix flags plus per-key held flags).
module tb_ps2_key_decoder;

    localparam int unsigned TO   = 300;
    localparam int unsigned HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [3:0] direction;
    logic       start;
    logic [7:0] scancode;
    logic       scan_valid;
    logic       frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .direction  (direction),
        .start      (start),
        .scancode   (scancode),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor, sampled on the falling clock edge
    int         mon_sv, mon_err, mon_dir_n, mon_st, mon_bad;
    int         mon_sv_cyc, mon_err_cyc, mon_dir_cyc, mon_st_cyc;
    logic [7:0] mon_code;
    logic [3:0] mon_dir;

    task automatic mon_clear();
        mon_sv = 0; mon_err = 0; mon_dir_n = 0; mon_st = 0; mon_bad = 0;
        mon_sv_cyc = 0; mon_err_cyc = 0; mon_dir_cyc = 0; mon_st_cyc = 0;
        mon_code = '0; mon_dir = '0;
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (scan_valid) begin mon_sv++; mon_code = scancode; mon_sv_cyc = cyc; end
            if (frame_err) begin mon_err++; mon_err_cyc = cyc; end
            if (direction != 4'b0) begin
                mon_dir_n++; mon_dir = direction; mon_dir_cyc = cyc;
                if (!$onehot(direction)) mon_bad++;
            end
            if (start) begin mon_st++; mon_st_cyc = cyc; end
        end
    end

    // Reference model
    bit         m_ext, m_brk;
    bit         m_held[5];
    logic [7:0] m_last;

    function automatic int key_of(input bit ext, input logic [7:0] d);
        if (ext) begin
            case (d)
                8'h75:   return 3;
                8'h72:   return 2;
                8'h6B:   return 1;
                8'h74:   return 0;
                default: return -1;
            endcase
        end
        return (d == 8'h1B) ? 4 : -1;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_last = '0;
        for (int k = 0; k < 5; k++) m_held[k] = 0;
    endtask

    int t_last;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            t_last  = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bit          valid;
        int          idx;
        logic [3:0]  edir;
        bit          est;
        bits = {~bad_stop, (~(^d)) ^ bad_par, d, 1'b0};
        mon_clear();
        send_bits(bits, 11);
        ps2_dat = 1'b1;
        wait_cycles(20);

        valid = !bad_stop && !(PAR_EN && bad_par);
        edir  = '0;
        est   = 0;
        if (valid) begin
            m_last = d;
            if (m_brk) begin
                idx = key_of(m_ext, d);
                if (idx >= 0) m_held[idx] = 0;
                m_ext = 0; m_brk = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else if (d == 8'hE0 && !m_ext) begin
                m_ext = 1;
            end else begin
                idx = key_of(m_ext, d);
                if (idx >= 0 && !m_held[idx]) begin
                    m_held[idx] = 1;
                    if (idx == 4) est = 1; else edir[idx] = 1'b1;
                end
                m_ext = 0;
            end
        end

        check("sv_cnt", mon_sv, valid ? 1 : 0);
        check("err_cnt", mon_err, valid ? 0 : 1);
        if (valid) begin
            check("sv_code", mon_code, d);
            check("sv_lat", mon_sv_cyc - t_last, 3);
        end else begin
            check("err_lat", mon_err_cyc - t_last, 3);
        end
        check("dir_cnt", mon_dir_n, (edir != 4'b0) ? 1 : 0);
        if (edir != 4'b0) begin
            check("dir_val", mon_dir, edir);
            check("dir_lat", mon_dir_cyc - t_last, 4);
        end
        check("start_cnt", mon_st, est ? 1 : 0);
        if (est) check("start_lat", mon_st_cyc - t_last, 4);
        check("onehot", mon_bad, 0);
        check("scancode_hold", scancode, m_last);
    endtask

    logic [7:0] pick [8];

    initial begin
        model_reset();
        mon_clear();
        pick[0] = 8'hE0; pick[1] = 8'hF0; pick[2] = 8'h75; pick[3] = 8'h72;
        pick[4] = 8'h6B; pick[5] = 8'h74; pick[6] = 8'h1B; pick[7] = 8'h00;

        wait_cycles(3);
        check("rst_direction", direction, 4'b0);
        check("rst_start", start, 1'b0);
        check("rst_scancode", scancode, 8'h00);
        check("rst_scan_valid", scan_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        resetn = 1'b1;
        wait_cycles(10);

        // Up arrow
        do_frame(8'hE0, 0, 0);
        do_frame(8'h75, 0, 0);
        // S with typematic repeats, break, and fresh make
        do_frame(8'h1B, 0, 0);
        do_frame(8'h1B, 0, 0);
        do_frame(8'h1B, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h1B, 0, 0);
        do_frame(8'h1B, 0, 0);
        // Left held, right, release left, left again
        do_frame(8'hE0, 0, 0); do_frame(8'h6B, 0, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'h74, 0, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'hF0, 0, 0); do_frame(8'h6B, 0, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'h6B, 0, 0);
        // Release up, then up with a wrong parity bit
        do_frame(8'hE0, 0, 0); do_frame(8'hF0, 0, 0); do_frame(8'h75, 0, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'h75, 1, 0);
        // Bad stop bit
        do_frame(8'h72, 0, 1);
        // Release S so the post-timeout make pulses
        do_frame(8'hF0, 0, 0); do_frame(8'h1B, 0, 0);

        // Partial frame abandoned by the watchdog
        mon_clear();
        send_bits({2'b11, 8'h1B, 1'b0}, 5);
        ps2_dat = 1'b1;
        wait_cycles(TO + 50);
        check("to_err_cnt", mon_err, 1);
        check("to_err_lat", mon_err_cyc - t_last, TO + 4);
        check("to_sv_cnt", mon_sv, 0);
        do_frame(8'h1B, 0, 0);

        // Reset mid-frame while down arrow is held
        do_frame(8'hE0, 0, 0); do_frame(8'h72, 0, 0);
        mon_clear();
        send_bits({2'b10, 8'h75, 1'b0}, 6);
        resetn = 1'b0;
        #3;
        check("mrst_direction", direction, 4'b0);
        check("mrst_start", start, 1'b0);
        check("mrst_scancode", scancode, 8'h00);
        check("mrst_scan_valid", scan_valid, 1'b0);
        check("mrst_frame_err", frame_err, 1'b0);
        model_reset();
        ps2_dat = 1'b1;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(TO + 50);
        check("mrst_no_strobe", mon_sv + mon_err + mon_dir_n + mon_st, 0);
        do_frame(8'hE0, 0, 0); do_frame(8'h72, 0, 0);

        // Randomized frames
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            int         sel;
            sel = $urandom_range(0, 7);
            d   = (sel == 7) ? 8'($urandom) : pick[sel];
            do_frame(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #5ms;
        n_fail++;
        $display("FAIL timeout global simulation limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard frames and turns arrow and S key presses into single-cycle game commands. Sits at the input side of `game2048`: it replaces the temporary switch inputs, driving the 4-bit direction bus (up, down, left, right) and the start/reset request from keyboard make codes. It also exposes every valid byte for debug.

## Interface
- `TIMEOUT_CYCLES`, default 50000: clock cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clock`  in  1  system clock, 50 MHz; all state is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clock`.
- `ps2_dat`  in  1  raw PS/2 data line, asynchronous to `clock`.
- `direction`  out  4  one-cycle one-hot pulse: [3] up, [2] down, [1] left, [0] right.
- `start`  out  1  one-cycle pulse on an S key make.
- `scancode`  out  8  last valid received byte.
- `scan_valid`  out  1  one-cycle strobe when `scancode` updates.
- `frame_err`  out  1  one-cycle strobe on a rejected or aborted frame.

## Operation
- **Input synchroniser:** two-flop synchroniser on each of `ps2_clk` and `ps2_dat`. A falling edge is the synchronised clock going 1→0, seen as previous 1, current 0.
- **Frame FSM, states IDLE and RECV:**
  - IDLE: a falling edge with data 0 (start bit) moves to RECV, bit count 0. Data 1 is ignored and the FSM stays in IDLE.
  - RECV: shift data in on each falling edge. Bits are: 8 data bits LSB first, then odd parity, then stop.
  - On the stop-bit edge, return to IDLE. The frame is valid if stop = 1 and the parity check passes (see Configuration).
  - A valid frame loads `scancode` and strobes `scan_valid`. An invalid frame strobes `frame_err` and produces no byte.
- **Watchdog:** counts cycles in RECV since the last falling edge. Reaching `TIMEOUT_CYCLES` forces IDLE, clears the bit count and strobes `frame_err`.
- **Code FSM, states BASE, EXT, BRK, EXT_BRK, one transition per valid byte:**
  - BASE: E0→EXT, F0→BRK, anything else is a base make.
  - EXT: F0→EXT_BRK, anything else is an extended make, then BASE.
  - BRK: base break, then BASE.
  - EXT_BRK: extended break, then BASE.
- **Key map:**
  - Extended codes: 75 up, 72 down, 6B left, 74 right.
  - Base code: 1B S.
  - Unmapped codes are dropped without error.
- **Held flags:** five flags, one per mapped key. A make with the flag clear pulses the output and sets the flag. A make with the flag set (typematic repeat) produces no pulse. A break clears the flag.
- Keys are independent, so several can be held at once. Each pulse is one-hot, because at most one byte completes per cycle.

## Timing
- Reset value of every output and register is 0. States reset to IDLE and BASE, and all held flags clear.
- `resetn` low mid-frame discards the partial frame immediately and emits no strobe.
- Latency from the raw stop-bit falling edge:
  - 2 cycles of synchronisation.
  - 1 cycle of edge detection, with `scan_valid` high in the cycle after.
  - `direction`/`start` high one cycle after `scan_valid`.
- `scancode` holds its value until the next valid frame.
- Watchdog timing: the count starts at 0 on each falling edge. The abort occurs at count == `TIMEOUT_CYCLES`.
- Falling edges are ignored while in IDLE with data 1. A glitch start therefore needs no timeout.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a frame whose 9 bits (data plus parity) hold an even number of ones is rejected with `frame_err`.
  - Undefined: the parity bit is shifted in and ignored, and only the stop bit validates the frame.

## Test plan
- Frames E0 (parity 0), then 75 (parity 0), at a 12.5 kHz PS/2 clock → `scan_valid` with 75, then a one-cycle `direction` = 4'b1000. `start` stays 0.
- 1B (parity 1), repeated three times without a break, then F0, 1B → exactly one `start` pulse. A further 1B after the break → a second pulse.
- E0 6B held, then 74, then E0 F0 6B → `direction` pulses 4'b0010, then 4'b0001. A new 6B make after the break pulses 4'b0010.
- 75 sent with parity 1, macro defined → `frame_err` pulse, no `scan_valid`, no `direction`. Macro undefined → `scan_valid` with 75.
- Start bit plus 4 bits, then the line idles for 50000 cycles → `frame_err` at timeout. A following full 1B frame decodes correctly to a `start` pulse.
- `resetn` pulsed low after 6 bits of a frame → all outputs 0, no strobe. A subsequent E0 72 yields `direction` = 4'b0100.
